// File: rtl/sap_pkg.sv
// Shared definitions for the SAP clock controller: FSM states, key indices, default timing.
package sap_pkg;

  typedef enum logic [1:0] {
    AUTO   = 2'd0,
    MANUAL = 2'd1,
    HALTED = 2'd2
  } sap_state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 50000;
  localparam int DEF_AUTO_DIV_BITS   = 18;

  localparam int NUM_KEYS = 3;
  localparam int KEY_STEP = 0;
  localparam int KEY_RST  = 1;
  localparam int KEY_MODE = 2;

endpackage

// File: rtl/sap_key_debounce.sv
// One push-button: 2-flop synchroniser, stable-count debouncer, single-cycle press pulse.
module sap_key_debounce
  import sap_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic pressed,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_pipe;
  logic          key_sync;
  logic          deb;
  logic          flip;
  logic [CW-1:0] cnt;

  assign key_sync = sync_pipe[1];
  // cnt holds how many earlier cycles already disagreed; this cycle completes the run
  assign flip     = (key_sync != deb) && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_pipe <= 2'b11;
      deb       <= 1'b1;
      cnt       <= '0;
      press     <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[0], key_raw};
      cnt       <= (key_sync == deb || flip) ? '0 : cnt + CW'(1);
      if (flip) deb <= key_sync;
      press     <= flip && deb;
    end
  end

  assign pressed = ~deb;

endmodule

// File: rtl/sap_clock_ctrl.sv
// SAP CPU clock controller: auto-run divider, manual stepping, halt and CPU reset.
// Define SAP_CLK_STEP_COUNT_EN to add the 16-bit step_count output.
module sap_clock_ctrl
  import sap_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int AUTO_DIV_BITS   = DEF_AUTO_DIV_BITS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_step,
  input  logic        key_rst,
  input  logic        key_mode,
  input  logic        halt,
  output logic        cpu_tick,
  output logic        cpu_reset,
  output logic        mode_manual,
  output logic        halted
`ifdef SAP_CLK_STEP_COUNT_EN
  ,
  output logic [15:0] step_count
`endif
);

  logic [NUM_KEYS-1:0] key_raw;
  logic [NUM_KEYS-1:0] key_lvl;
  logic [NUM_KEYS-1:0] key_press;
  logic                lvl_unused;

  assign key_raw = {key_mode, key_rst, key_step};

  sap_key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key [NUM_KEYS-1:0] (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_raw(key_raw),
    .pressed(key_lvl),
    .press  (key_press)
  );

  // only the reset key is consumed as a level; step/mode act on press edges
  assign lvl_unused = key_lvl[KEY_STEP] | key_lvl[KEY_MODE];

  sap_state_e               state, state_nxt;
  logic                     mode_q, mode_nxt;
  logic                     tick_q, tick_nxt;
  logic                     hold;
  logic [AUTO_DIV_BITS-1:0] div_q, div_nxt;
  logic                     rst_lvl;

  assign rst_lvl = key_lvl[KEY_RST];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= AUTO;
      mode_q <= 1'b0;
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      mode_q <= mode_nxt;
      div_q  <= div_nxt;
      tick_q <= tick_nxt;
    end
  end

  always_comb begin
    mode_nxt  = mode_q ^ key_press[KEY_MODE];
    state_nxt = state;
    case (state)
      AUTO, MANUAL: begin
        if (key_press[KEY_MODE]) state_nxt = mode_nxt ? MANUAL : AUTO;
        if (halt && !rst_lvl)    state_nxt = HALTED;
      end
      default: ;
    endcase
    if (key_press[KEY_RST]) state_nxt = mode_nxt ? MANUAL : AUTO;

    // any state change (toggle, halt, reset) cancels the tick and restarts the divider
    hold     = !rst_lvl && (state_nxt == state);
    tick_nxt = hold && ((state == AUTO && (&div_q)) ||
                        (state == MANUAL && key_press[KEY_STEP]));
    div_nxt  = (hold && state == AUTO) ? div_q + AUTO_DIV_BITS'(1) : '0;
  end

  assign cpu_tick    = tick_q & ~rst_lvl;
  assign cpu_reset   = rst_lvl;
  assign mode_manual = mode_q;
  assign halted      = (state == HALTED);

`ifdef SAP_CLK_STEP_COUNT_EN
  logic [15:0] step_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        step_cnt_q <= '0;
    else if (rst_lvl)  step_cnt_q <= '0;
    else if (cpu_tick) step_cnt_q <= step_cnt_q + 16'd1;
  end

  assign step_count = step_cnt_q;
`endif

endmodule

// File: tb/tb_sap_clock_ctrl.sv
// Bench for sap_clock_ctrl: directed scenarios plus random key/halt traffic vs a behavioural model.
module tb_sap_clock_ctrl;

  localparam int DB     = 4;
  localparam int DIVB   = 3;
  localparam int PER    = 1 << DIVB;
  localparam int K_STEP = 0;
  localparam int K_RST  = 1;
  localparam int K_MODE = 2;

  logic clk      = 1'b0;
  logic rst_n    = 1'b1;
  logic key_step = 1'b1;
  logic key_rst  = 1'b1;
  logic key_mode = 1'b1;
  logic halt     = 1'b0;
  logic cpu_tick, cpu_reset, mode_manual, halted;
`ifdef SAP_CLK_STEP_COUNT_EN
  logic [15:0] step_count;
`endif

  sap_clock_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .AUTO_DIV_BITS  (DIVB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_step   (key_step),
    .key_rst    (key_rst),
    .key_mode   (key_mode),
    .halt       (halt),
    .cpu_tick   (cpu_tick),
    .cpu_reset  (cpu_reset),
    .mode_manual(mode_manual),
    .halted     (halted)
`ifdef SAP_CLK_STEP_COUNT_EN
    ,
    .step_count (step_count)
`endif
  );

  always #5 clk = ~clk;

  int checks     = 0;
  int errors     = 0;
  int ticks_seen = 0;
  int cyc_no     = 0;
  int first_tick = -1;

  // Model: a key's debounced level flips once the last DB synchronised samples
  // (raw delayed by two clocks) all disagree with it; the controller is {halted, mode}.
  bit          m_mode, m_halted, m_tick;
  int          m_phase;
  logic [15:0] m_count;
  bit          m_deb   [3];
  bit          m_press [3];
  bit          raw_q   [3][$];
  bit          win     [3][$];

  task automatic model_reset();
    m_mode = 0; m_halted = 0; m_tick = 0; m_phase = 0; m_count = '0;
    for (int k = 0; k < 3; k++) begin
      m_deb[k] = 1; m_press[k] = 0;
      raw_q[k].delete(); raw_q[k].push_back(1'b1); raw_q[k].push_back(1'b1);
      win[k].delete();
    end
  endtask

  task automatic model_edge();
    bit raw [3];
    bit rst_lvl, new_halted, run_same, tick_n, sv, flip;
    raw[K_STEP] = key_step; raw[K_RST] = key_rst; raw[K_MODE] = key_mode;
    if (!m_deb[K_RST]) m_count = '0;
    else if (m_tick)   m_count = m_count + 16'd1;
    rst_lvl    = !m_deb[K_RST];
    new_halted = m_halted;
    if (!m_halted && halt && !rst_lvl) new_halted = 1'b1;
    if (m_press[K_RST])                new_halted = 1'b0;
    run_same = !rst_lvl && !m_halted && !new_halted && !m_press[K_MODE];
    tick_n   = run_same && (m_mode ? m_press[K_STEP] : (m_phase == PER - 1));
    m_phase  = (run_same && !m_mode) ? (m_phase + 1) % PER : 0;
    m_mode   = m_mode ^ m_press[K_MODE];
    m_halted = new_halted;
    for (int k = 0; k < 3; k++) begin
      sv = raw_q[k][1];
      raw_q[k].push_front(raw[k]);
      void'(raw_q[k].pop_back());
      win[k].push_front(sv);
      if (win[k].size() > DB) void'(win[k].pop_back());
      flip = (win[k].size() == DB);
      for (int i = 0; i < win[k].size(); i++)
        if (win[k][i] == m_deb[k]) flip = 0;
      m_press[k] = flip && m_deb[k];
      if (flip) m_deb[k] = !m_deb[k];
    end
    m_tick = tick_n && m_deb[K_RST];
  endtask

  task automatic chk1(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d obs=%0b exp=%0b", tag, cyc_no, obs, exp);
    end
  endtask

  task automatic chk_int(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    cyc_no++;
    chk1("cpu_tick", cpu_tick, m_tick);
    chk1("cpu_reset", cpu_reset, !m_deb[K_RST]);
    chk1("mode_manual", mode_manual, m_mode);
    chk1("halted", halted, m_halted);
`ifdef SAP_CLK_STEP_COUNT_EN
    checks++;
    assert (step_count === m_count) else begin
      errors++;
      $error("FAIL step_count cyc=%0d obs=%0d exp=%0d", cyc_no, step_count, m_count);
    end
`endif
    if (cpu_tick) begin
      ticks_seen++;
      if (first_tick < 0) first_tick = cyc_no;
    end
  endtask

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic set_key(int k, logic v);
    case (k)
      K_STEP:  key_step = v;
      K_RST:   key_rst  = v;
      default: key_mode = v;
    endcase
  endtask

  task automatic press_key(int k, int low, int high);
    set_key(k, 1'b0);
    cyc(low);
    set_key(k, 1'b1);
    cyc(high);
  endtask

  task automatic chk_reset_outputs(string tag);
    chk1({tag, "_tick"}, cpu_tick, 1'b0);
    chk1({tag, "_cpu_reset"}, cpu_reset, 1'b0);
    chk1({tag, "_mode"}, mode_manual, 1'b0);
    chk1({tag, "_halted"}, halted, 1'b0);
  endtask

  initial begin
    model_reset();
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // free-running auto ticks after reset release
    cyc_no = 0; ticks_seen = 0; first_tick = -1;
    cyc(5 * PER);
    chk_int("first_auto_tick", first_tick, PER);
    chk_int("auto_tick_count", ticks_seen, 5);
    chk1("auto_mode", mode_manual, 1'b0);

    // long mode hold toggles once
    key_mode = 1'b0;
    cyc(10);
    chk1("mode_toggle", mode_manual, 1'b1);
    key_mode = 1'b1;
    cyc(8);

    // short / glitching step key must not step
    ticks_seen = 0;
    key_step = 1'b0;
    cyc(DB - 1);
    repeat (12) begin
      key_step = ~key_step;
      cyc(1);
    end
    key_step = 1'b1;
    cyc(20);
    chk_int("glitch_ticks", ticks_seen, 0);

    // manual stepping
    ticks_seen = 0;
    repeat (3) press_key(K_STEP, 6, 8);
    chk_int("manual_three", ticks_seen, 3);
    ticks_seen = 0;
    press_key(K_STEP, 100, 10);
    chk_int("manual_hold", ticks_seen, 1);

    // back to auto, halt exactly on the wrap cycle
    press_key(K_MODE, 6, 8);
    chk1("back_auto", mode_manual, 1'b0);
    for (int g = 0; g < 2 * PER && m_phase != PER - 1; g++) cyc(1);
    chk_int("phase_sync", m_phase, PER - 1);
    halt = 1'b1;
    cyc(1);
    halt = 1'b0;
    chk1("halt_no_tick", cpu_tick, 1'b0);
    chk1("halt_enter", halted, 1'b1);
    cyc(4);
    key_rst = 1'b0;
    cyc(10);
    chk1("rst_held", cpu_reset, 1'b1);
    chk1("rst_leaves_halt", halted, 1'b0);
    key_rst = 1'b1;
    cyc_no = 0; ticks_seen = 0; first_tick = -1;
    cyc(30);
    chk_int("div_restart", first_tick, 2 + DB + PER);

    // mode press while halted only flips the stored mode
    halt = 1'b1;
    cyc(1);
    halt = 1'b0;
    cyc(2);
    chk1("halt2", halted, 1'b1);
    press_key(K_MODE, 6, 8);
    chk1("halted_mode_halt", halted, 1'b1);
    chk1("halted_mode_flip", mode_manual, 1'b1);
    press_key(K_RST, 6, 8);
    chk1("rst_to_manual_halt", halted, 1'b0);
    chk1("rst_to_manual_mode", mode_manual, 1'b1);

    // async reset in the middle of a step debounce
    key_step = 1'b0;
    cyc(3);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("mid_rst");
    model_reset();
    key_step = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ticks_seen = 0;
    cyc(PER - 1);
    chk_int("no_tick_after_rst", ticks_seen, 0);
    cyc(4);

    // random key and halt traffic
    repeat (60) begin
      int k;
      k = $urandom_range(0, 2);
      set_key(k, 1'b0);
      repeat ($urandom_range(1, 9)) begin
        halt = ($urandom_range(0, 15) == 0);
        cyc(1);
      end
      set_key(k, 1'b1);
      repeat ($urandom_range(1, 10)) begin
        halt = ($urandom_range(0, 15) == 0);
        cyc(1);
      end
    end
    halt = 1'b0;
    cyc(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
